tile_host_driver: RTL and testbench
===================================

Name: tile_host_driver

Overview:
- Host-side initiator for one accelerator tile: drives the accelerator's config, load, start and readback port set from one input word stream, and returns ofmap words on one output stream.
- Sequence: config handshake, ifmap load, bias load, weight load, op_go, wait tile_done, ofmap readback, op_done.
- Sits between the system DMA/stream fabric and the accelerator top level, one instance per accelerator.

Parameters:
- WD, 8, pixel width in bits.
- NL, 8, lanes per buffer word (bus width NL*WD = 64).
- AW, 10, buffer address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle tile start pulse; ignored while busy.
- ifmap_words  in  AW+1  ifmap word count, 0..1024, latched at start.
- wght_words  in  AW+1  weight word count, 0..1024, latched at start.
- ofmap_words  in  AW+1  ofmap word count to read back, 0..1024, latched at start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at tile completion.
- s_valid / s_ready / s_data  in / out / NL*WD  input stream; word order is ifmap words, then 2 bias words, then weight words.
- m_valid / m_ready / m_data / m_last  out / in / NL*WD / out  ofmap output stream; m_last flags the final word.
- config_load, config_done, ifmap_ready, wght_ready, op_go, op_done, bias_write  out  1  accelerator control strobes.
- ifmap_en, wght_en, ofmap_en  out  1  accelerator buffer port enables.
- ifmap_wen, wght_wen  out  NL  byte write enables.
- ifmap_addrin, wght_addrin, ofmap_addrin  out  AW  buffer addresses.
- ifmap_din, wght_din  out  NL*WD  write data.
- dataload_ready, tile_done  in  1  accelerator status.
- FSM  in  4  accelerator state.
- ofmap_dout  in  NL*WD  ofmap read data; valid 1 cycle after ofmap_en.

Behaviour:
- Reset, asynchronous, active-low:
  - State goes to IDLE.
  - All outputs go to 0: strobes, enables, wen, addresses, data, s_ready, m_valid, m_last, busy, done.
  - Output buffer is emptied and counters are cleared.
  - Reset mid-tile aborts the tile with no done pulse.
- States:
  - IDLE: on start, latch the three counts and go to CFG_LD.
  - CFG_LD: config_load=1 for 1 cycle, then CFG_DN.
  - CFG_DN: config_done=1 for 1 cycle, then LD_IF.
  - LD_IF: s_ready=1. Each beat where s_valid&s_ready does ifmap_en=1, ifmap_wen=8'hFF, ifmap_din=s_data, ifmap_addrin=beat index from 0. Leave after ifmap_words beats; a count of 0 leaves immediately with no s_ready.
  - IF_RDY: ifmap_ready=1 for 1 cycle.
  - BIAS_W: bias_write=1 held. s_ready=0 until FSM==4'd2. Then accept 2 beats on the wght port: wght_en=1, wght_wen=8'hFF, addresses 0 and 1. Drop bias_write after the second beat.
  - LD_WT: same as LD_IF but on the wght port, with the address restarting at 0.
  - WT_RDY: wght_ready=1 for 1 cycle.
  - WAIT_DL: hold until dataload_ready=1.
  - GO: op_go=1 for 1 cycle.
  - WAIT_T: hold until tile_done=1.
  - RD_OF: readback (see below); leave when all ofmap_words words have been accepted on m.
  - FIN: op_done=1 and done=1 for 1 cycle, then IDLE.
- Readback:
  - Use a 2-entry output buffer plus an in-flight flag.
  - Issue a read (ofmap_en=1, ofmap_addrin=next address) only when (occupancy minus a pop this cycle) + in-flight < 2 and words remain to issue.
  - Capture ofmap_dout into the buffer the cycle after issue.
  - With m_ready held high this sustains 1 word/cycle after 1 cycle of latency.
  - m_data and m_valid come from the buffer head and stay stable while m_valid&!m_ready.
  - m_last=1 on word ofmap_words-1.
  - ofmap_words=0 skips straight to FIN.
- Input flow: s_ready is registered and never asserted outside LD_IF, BIAS_W (with FSM==2) and LD_WT. Beats beyond the current phase's count are not accepted.
- Counters are AW+1 bits. Address equals the low AW bits of the beat index; a count of 1024 ends at address 1023 with no wrap.
- start is ignored when busy=1 or done=1.

Test Plan:
- Counts 4/4/4, s_valid always high -> one cycle each of config_load then config_done; ifmap addresses 0..3 on 4 consecutive cycles; one ifmap_ready pulse; bias written at wght addresses 0,1 only once FSM==2; weight addresses 0..3; one wght_ready pulse.
- FSM held at 1 for 5 cycles during BIAS_W -> bias_write stays high, s_ready stays 0 and no wght_en until FSM==2.
- ofmap_words=6, m_ready=1, ofmap_dout = address+100 -> m_data sequence 100..105 on consecutive cycles, m_last on 105, then op_done and done pulse once.
- ofmap_words=5, m_ready toggled 1010… -> no lost or duplicated words, m_data stable while stalled, at most 2 reads outstanding.
- Counts 0/0/0 -> IF_RDY and WT_RDY still pulse, the two bias beats still occur, no ifmap or ofmap accesses, done follows op_done.
- rst driven low during LD_WT at beat 2 -> all outputs 0 immediately; a new start after reset release runs a full tile from CFG_LD.

Source files
------------

// File: rtl/tile_host_driver.sv
// Host-side initiator for one accelerator tile. One input stream feeds the
// ifmap, bias and weight buffers in that order. After the tile has run, the
// ofmap buffer is read back through a 2-entry skid buffer onto the output stream.
module tile_host_driver #(
  parameter int WD = 8,
  parameter int NL = 8,
  parameter int AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [AW:0]        ifmap_words,
  input  logic [AW:0]        wght_words,
  input  logic [AW:0]        ofmap_words,
  output logic               busy,
  output logic               done,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [NL*WD-1:0]   s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [NL*WD-1:0]   m_data,
  output logic               m_last,
  output logic               config_load,
  output logic               config_done,
  output logic               ifmap_ready,
  output logic               wght_ready,
  output logic               op_go,
  output logic               op_done,
  output logic               bias_write,
  output logic               ifmap_en,
  output logic               wght_en,
  output logic               ofmap_en,
  output logic [NL-1:0]      ifmap_wen,
  output logic [NL-1:0]      wght_wen,
  output logic [AW-1:0]      ifmap_addrin,
  output logic [AW-1:0]      wght_addrin,
  output logic [AW-1:0]      ofmap_addrin,
  output logic [NL*WD-1:0]   ifmap_din,
  output logic [NL*WD-1:0]   wght_din,
  input  logic               dataload_ready,
  input  logic               tile_done,
  input  logic [3:0]         FSM,
  input  logic [NL*WD-1:0]   ofmap_dout
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_LD, S_CFG_DN, S_LD_IF, S_IF_RDY, S_BIAS_W, S_LD_WT,
    S_WT_RDY, S_WAIT_DL, S_GO, S_WAIT_T, S_RD_OF, S_FIN
  } state_t;

  localparam logic [AW:0] BIAS_BEATS = (AW+1)'(2);
  localparam logic [3:0]  ACC_LOAD   = 4'd2;

  state_t             state_q, state_d;
  logic [AW:0]        if_n_q, if_n_d, wt_n_q, wt_n_d, of_n_q, of_n_d;
  logic [AW:0]        cnt_q, cnt_d;   // beat index while loading, read-issue index in readback
  logic [AW:0]        out_q, out_d;   // words accepted on m
  logic               s_ready_q, s_ready_d;
  logic [1:0]         occ_q, occ_d;
  logic               infl_q, infl_d;
  logic [NL*WD-1:0]   buf0_q, buf0_d, buf1_q, buf1_d;

  logic               s_acc, pop, rd_issue;
  logic [1:0]         occ_after;

  assign s_acc     = s_valid & s_ready_q;
  assign m_valid   = (occ_q != 2'd0);
  assign pop       = m_valid & m_ready;
  assign occ_after = occ_q - {1'b0, pop};
  assign rd_issue  = (state_q == S_RD_OF) && ((occ_after + {1'b0, infl_q}) < 2'd2) &&
                     (cnt_q < of_n_q);

  // Next-state, counters, readback buffer and registered s_ready
  always_comb begin
    state_d = state_q;
    if_n_d  = if_n_q;
    wt_n_d  = wt_n_q;
    of_n_d  = of_n_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    occ_d   = occ_after + {1'b0, infl_q};
    infl_d  = rd_issue;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    if (pop) buf0_d = buf1_q;
    if (infl_q) begin
      if (occ_after == 2'd0) buf0_d = ofmap_dout;
      else                   buf1_d = ofmap_dout;
    end
    case (state_q)
      S_IDLE: if (start) begin
        if_n_d  = ifmap_words;
        wt_n_d  = wght_words;
        of_n_d  = ofmap_words;
        cnt_d   = '0;
        out_d   = '0;
        state_d = S_CFG_LD;
      end
      S_CFG_LD: state_d = S_CFG_DN;
      S_CFG_DN: state_d = S_LD_IF;
      S_LD_IF: begin
        if (s_acc) cnt_d = cnt_q + 1'b1;
        if (cnt_d == if_n_q) begin
          cnt_d   = '0;
          state_d = S_IF_RDY;
        end
      end
      S_IF_RDY: state_d = S_BIAS_W;
      S_BIAS_W: begin
        if (s_acc) cnt_d = cnt_q + 1'b1;
        if (cnt_d == BIAS_BEATS) begin
          cnt_d   = '0;
          state_d = S_LD_WT;
        end
      end
      S_LD_WT: begin
        if (s_acc) cnt_d = cnt_q + 1'b1;
        if (cnt_d == wt_n_q) begin
          cnt_d   = '0;
          state_d = S_WT_RDY;
        end
      end
      S_WT_RDY:  state_d = S_WAIT_DL;
      S_WAIT_DL: if (dataload_ready) state_d = S_GO;
      S_GO:      state_d = S_WAIT_T;
      S_WAIT_T:  if (tile_done) state_d = (of_n_q == '0) ? S_FIN : S_RD_OF;
      S_RD_OF: begin
        if (rd_issue) cnt_d = cnt_q + 1'b1;
        if (pop)      out_d = out_q + 1'b1;
        if (out_d == of_n_q) begin
          cnt_d   = '0;
          out_d   = '0;
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // s_ready is a flop, so it is decided from where the FSM will be next cycle
    case (state_d)
      S_LD_IF:  s_ready_d = (cnt_d < if_n_q);
      S_BIAS_W: s_ready_d = (FSM == ACC_LOAD) && (cnt_d < BIAS_BEATS);
      S_LD_WT:  s_ready_d = (cnt_d < wt_n_q);
      default:  s_ready_d = 1'b0;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      if_n_q    <= '0;
      wt_n_q    <= '0;
      of_n_q    <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      s_ready_q <= 1'b0;
      occ_q     <= 2'd0;
      infl_q    <= 1'b0;
      buf0_q    <= '0;
      buf1_q    <= '0;
    end else begin
      state_q   <= state_d;
      if_n_q    <= if_n_d;
      wt_n_q    <= wt_n_d;
      of_n_q    <= of_n_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      s_ready_q <= s_ready_d;
      occ_q     <= occ_d;
      infl_q    <= infl_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign op_done     = (state_q == S_FIN);
  assign config_load = (state_q == S_CFG_LD);
  assign config_done = (state_q == S_CFG_DN);
  assign ifmap_ready = (state_q == S_IF_RDY);
  assign wght_ready  = (state_q == S_WT_RDY);
  assign op_go       = (state_q == S_GO);
  assign bias_write  = (state_q == S_BIAS_W);

  assign ifmap_en     = (state_q == S_LD_IF) && s_acc;
  assign ifmap_wen    = {NL{ifmap_en}};
  assign ifmap_addrin = ifmap_en ? cnt_q[AW-1:0] : '0;
  assign ifmap_din    = ifmap_en ? s_data : '0;

  assign wght_en      = ((state_q == S_BIAS_W) || (state_q == S_LD_WT)) && s_acc;
  assign wght_wen     = {NL{wght_en}};
  assign wght_addrin  = wght_en ? cnt_q[AW-1:0] : '0;
  assign wght_din     = wght_en ? s_data : '0;

  assign ofmap_en     = rd_issue;
  assign ofmap_addrin = rd_issue ? cnt_q[AW-1:0] : '0;

  assign m_data = m_valid ? buf0_q : '0;
  assign m_last = m_valid && (out_q == (of_n_q - (AW+1)'(1)));

endmodule

// File: tb/tb_tile_host_driver.sv
// Directed bench for tile_host_driver: a cycle-stepping tile runner records
// accelerator-side activity, and each test task compares it to hand-derived values.
module tb_tile_host_driver;
  localparam int WD = 8;
  localparam int NL = 8;
  localparam int AW = 10;
  localparam int DW = NL*WD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [AW:0] ifmap_words = '0, wght_words = '0, ofmap_words = '0;
  logic busy, done;
  logic s_valid = 1'b0, s_ready;
  logic [DW-1:0] s_data = '0;
  logic m_valid, m_ready = 1'b0, m_last;
  logic [DW-1:0] m_data;
  logic config_load, config_done, ifmap_ready, wght_ready, op_go, op_done, bias_write;
  logic ifmap_en, wght_en, ofmap_en;
  logic [NL-1:0] ifmap_wen, wght_wen;
  logic [AW-1:0] ifmap_addrin, wght_addrin, ofmap_addrin;
  logic [DW-1:0] ifmap_din, wght_din;
  logic dataload_ready = 1'b0, tile_done = 1'b0;
  logic [3:0] fsm_st = 4'd0;
  logic [DW-1:0] ofmap_dout = '0;

  tile_host_driver #(.WD(WD), .NL(NL), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ifmap_words(ifmap_words), .wght_words(wght_words), .ofmap_words(ofmap_words),
    .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .config_load(config_load), .config_done(config_done), .ifmap_ready(ifmap_ready),
    .wght_ready(wght_ready), .op_go(op_go), .op_done(op_done), .bias_write(bias_write),
    .ifmap_en(ifmap_en), .wght_en(wght_en), .ofmap_en(ofmap_en),
    .ifmap_wen(ifmap_wen), .wght_wen(wght_wen),
    .ifmap_addrin(ifmap_addrin), .wght_addrin(wght_addrin), .ofmap_addrin(ofmap_addrin),
    .ifmap_din(ifmap_din), .wght_din(wght_din),
    .dataload_ready(dataload_ready), .tile_done(tile_done),
    .FSM(fsm_st), .ofmap_dout(ofmap_dout)
  );

  always #5 clk = ~clk;

  // Ofmap buffer model: read data is address+100, one cycle after the enable
  always @(posedge clk)
    ofmap_dout <= ofmap_en ? (64'(ofmap_addrin) + 64'd100) : 64'hDEAD_BEEF_0000_0000;

  int tests_run = 0;
  int tests_failed = 0;

  int cfg_ld_n, cfg_ld_cyc, cfg_dn_n, cfg_dn_cyc, if_rdy_n, wt_rdy_n;
  int op_done_n, op_done_cyc, done_n, done_cyc, bw_n, bias_early, bad_wdata;
  int last_n, stall_bad, max_out, of_iss, busy_after;
  bit timeout, aborted;
  logic [DW-1:0] last_dat;
  int if_addr[$], if_cyc[$], wt_addr[$], wt_cyc[$], bias_addr[$], bias_cyc[$], m_cyc[$];
  logic [DW-1:0] m_dat[$];

  function automatic logic any_out();
    return busy | done | s_ready | m_valid | m_last | config_load | config_done |
           ifmap_ready | wght_ready | op_go | op_done | bias_write | ifmap_en |
           wght_en | ofmap_en | (|ifmap_wen) | (|wght_wen) | (|ifmap_addrin) |
           (|wght_addrin) | (|ofmap_addrin) | (|ifmap_din) | (|wght_din) | (|m_data);
  endfunction

  // Runs one tile from a start pulse, recording everything seen on the DUT outputs.
  // hold: cycles of bias_write seen before FSM moves from 1 to 2.
  // abort_beat: LD_WT beat index at which rst is pulled low (-1 = never).
  task automatic run_tile(input int ni, input int nw, input int no, input int hold,
                          input bit toggle, input int abort_beat);
    int bwc, iss, acc;
    bit prev_stall, finished;
    logic [DW-1:0] prev_dat;
    cfg_ld_n = 0; cfg_ld_cyc = -1; cfg_dn_n = 0; cfg_dn_cyc = -1;
    if_rdy_n = 0; wt_rdy_n = 0; op_done_n = 0; op_done_cyc = -1;
    done_n = 0; done_cyc = -1; bw_n = 0; bias_early = 0; bad_wdata = 0;
    last_n = 0; last_dat = '0; stall_bad = 0; max_out = 0; of_iss = 0;
    busy_after = -1; timeout = 0; aborted = 0;
    if_addr.delete(); if_cyc.delete(); wt_addr.delete(); wt_cyc.delete();
    bias_addr.delete(); bias_cyc.delete(); m_dat.delete(); m_cyc.delete();
    bwc = 0; iss = 0; acc = 0; prev_stall = 0; prev_dat = '0; finished = 0;
    @(negedge clk);
    ifmap_words = (AW+1)'(ni); wght_words = (AW+1)'(nw); ofmap_words = (AW+1)'(no);
    s_valid = 1'b1; dataload_ready = 1'b1; tile_done = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start   = (cyc == 0) || (cyc == 10);
      fsm_st  = (bwc >= hold) ? 4'd2 : 4'd1;
      m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      s_data  = 64'hA000_0000_0000_0000 | 64'(cyc);
      #1;
      if (config_load) begin cfg_ld_n++; cfg_ld_cyc = cyc; end
      if (config_done) begin cfg_dn_n++; cfg_dn_cyc = cyc; end
      if (ifmap_ready) if_rdy_n++;
      if (wght_ready)  wt_rdy_n++;
      if (ifmap_en) begin
        if_addr.push_back(int'(ifmap_addrin)); if_cyc.push_back(cyc);
        if (ifmap_din !== s_data || ifmap_wen !== 8'hFF) bad_wdata++;
      end
      if (wght_en) begin
        if (bias_write) begin bias_addr.push_back(int'(wght_addrin)); bias_cyc.push_back(cyc); end
        else begin wt_addr.push_back(int'(wght_addrin)); wt_cyc.push_back(cyc); end
        if (wght_din !== s_data || wght_wen !== 8'hFF) bad_wdata++;
      end
      if (bias_write) begin
        bwc++; bw_n++;
        if (fsm_st != 4'd2 && (s_ready || wght_en)) bias_early++;
      end
      if (ofmap_en) begin iss++; of_iss++; end
      if (prev_stall && (!m_valid || m_data !== prev_dat)) stall_bad++;
      prev_stall = m_valid && !m_ready;
      prev_dat = m_data;
      if (m_valid && m_ready) begin
        m_dat.push_back(m_data); m_cyc.push_back(cyc); acc++;
        if (m_last) begin last_n++; last_dat = m_data; end
      end
      if (iss - acc > max_out) max_out = iss - acc;
      if (op_done) begin op_done_n++; op_done_cyc = cyc; end
      if (done) begin done_n++; done_cyc = cyc; end
      if (abort_beat >= 0 && wght_en && !bias_write && wt_addr.size() == abort_beat + 1) begin
        #2 rst = 1'b0;
        aborted = 1;
        start = 1'b0;
        return;
      end
      if (done_n > 0 && cyc == done_cyc + 1) begin
        busy_after = int'(busy);
        finished = 1;
        break;
      end
    end
    start = 1'b0;
    if (!finished) timeout = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; ifmap_words = 11'd4;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (any_out() !== 1'b0) begin
      tests_failed++; $display("FAIL reset_outputs: got any=%0b expected 0", any_out());
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_start_ignored: got busy=%0b expected 0", busy);
    end
    @(negedge clk); start = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_release_idle: got busy=%0b s_ready=%0b expected 0 0", busy, s_ready);
    end
  endtask

  task automatic test_load();
    bit ok;
    run_tile(4, 4, 2, 5, 1'b0, -1);
    tests_run++;
    if (timeout !== 1'b0) begin tests_failed++; $display("FAIL load_timeout: got 1 expected 0"); end
    tests_run++;
    if (cfg_ld_n != 1 || cfg_ld_cyc != 1 || cfg_dn_n != 1 || cfg_dn_cyc != 2) begin
      tests_failed++;
      $display("FAIL load_cfg: got ld n=%0d cyc=%0d dn n=%0d cyc=%0d expected 1 1 1 2",
               cfg_ld_n, cfg_ld_cyc, cfg_dn_n, cfg_dn_cyc);
    end
    ok = (if_addr.size() == 4);
    if (ok) for (int i = 0; i < 4; i++) if (if_addr[i] != i || if_cyc[i] != 3 + i) ok = 0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL load_ifmap_seq: got %0d beats first_cyc=%0d expected 4 beats addr 0..3 at 3..6",
               if_addr.size(), (if_cyc.size() > 0) ? if_cyc[0] : -1);
    end
    tests_run++;
    if (if_rdy_n != 1 || wt_rdy_n != 1) begin
      tests_failed++; $display("FAIL load_rdy_pulses: got if=%0d wt=%0d expected 1 1", if_rdy_n, wt_rdy_n);
    end
    tests_run++;
    if (bw_n != 8 || bias_early != 0) begin
      tests_failed++; $display("FAIL load_bias_hold: got bias_write cycles=%0d early=%0d expected 8 0", bw_n, bias_early);
    end
    ok = (bias_addr.size() == 2);
    if (ok) for (int i = 0; i < 2; i++) if (bias_addr[i] != i || bias_cyc[i] != 14 + i) ok = 0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL load_bias_beats: got %0d beats first_cyc=%0d expected 2 beats addr 0,1 at 14,15",
               bias_addr.size(), (bias_cyc.size() > 0) ? bias_cyc[0] : -1);
    end
    ok = (wt_addr.size() == 4);
    if (ok) for (int i = 0; i < 4; i++) if (wt_addr[i] != i || wt_cyc[i] != 16 + i) ok = 0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL load_wght_seq: got %0d beats first_cyc=%0d expected 4 beats addr 0..3 at 16..19",
               wt_addr.size(), (wt_cyc.size() > 0) ? wt_cyc[0] : -1);
    end
    tests_run++;
    if (bad_wdata != 0) begin
      tests_failed++; $display("FAIL load_wdata: got %0d bad beats expected 0", bad_wdata);
    end
    tests_run++;
    if (done_n != 1 || done_cyc != 28 || busy_after != 0) begin
      tests_failed++;
      $display("FAIL load_done: got n=%0d cyc=%0d busy_after=%0d expected 1 28 0", done_n, done_cyc, busy_after);
    end
  endtask

  task automatic test_readback();
    bit ok;
    run_tile(1, 1, 6, 0, 1'b0, -1);
    ok = (m_dat.size() == 6);
    if (ok) for (int i = 0; i < 6; i++) if (m_dat[i] !== 64'(100 + i) || m_cyc[i] != 14 + i) ok = 0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rb_sequence: got %0d words first=%0d at cyc %0d expected 6 words 100..105 at 14..19",
               m_dat.size(), (m_dat.size() > 0) ? m_dat[0] : '0, (m_cyc.size() > 0) ? m_cyc[0] : -1);
    end
    tests_run++;
    if (last_n != 1 || last_dat !== 64'd105) begin
      tests_failed++; $display("FAIL rb_last: got n=%0d data=%0d expected 1 105", last_n, last_dat);
    end
    tests_run++;
    if (op_done_n != 1 || done_n != 1 || op_done_cyc != 20 || done_cyc != 20) begin
      tests_failed++;
      $display("FAIL rb_done: got op_done n=%0d cyc=%0d done n=%0d cyc=%0d expected 1 20 1 20",
               op_done_n, op_done_cyc, done_n, done_cyc);
    end
  endtask

  task automatic test_stall();
    bit ok;
    run_tile(1, 1, 5, 0, 1'b1, -1);
    ok = (m_dat.size() == 5);
    if (ok) for (int i = 0; i < 5; i++) if (m_dat[i] !== 64'(100 + i)) ok = 0;
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL stall_sequence: got %0d words expected 5 words 100..104", m_dat.size());
    end
    tests_run++;
    if (stall_bad != 0) begin
      tests_failed++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", stall_bad);
    end
    tests_run++;
    if (max_out > 2 || of_iss != 5) begin
      tests_failed++; $display("FAIL stall_outstanding: got max=%0d reads=%0d expected <=2 5", max_out, of_iss);
    end
    tests_run++;
    if (last_n != 1 || last_dat !== 64'd104 || done_n != 1 || done_cyc != 23) begin
      tests_failed++;
      $display("FAIL stall_end: got last n=%0d data=%0d done n=%0d cyc=%0d expected 1 104 1 23",
               last_n, last_dat, done_n, done_cyc);
    end
  endtask

  task automatic test_zero();
    run_tile(0, 0, 0, 0, 1'b0, -1);
    tests_run++;
    if (if_rdy_n != 1 || wt_rdy_n != 1) begin
      tests_failed++; $display("FAIL zero_rdy_pulses: got if=%0d wt=%0d expected 1 1", if_rdy_n, wt_rdy_n);
    end
    tests_run++;
    if (bias_addr.size() != 2 || if_addr.size() != 0 || wt_addr.size() != 0) begin
      tests_failed++;
      $display("FAIL zero_beats: got bias=%0d ifmap=%0d wght=%0d expected 2 0 0",
               bias_addr.size(), if_addr.size(), wt_addr.size());
    end
    tests_run++;
    if (of_iss != 0 || m_dat.size() != 0) begin
      tests_failed++; $display("FAIL zero_ofmap: got reads=%0d words=%0d expected 0 0", of_iss, m_dat.size());
    end
    tests_run++;
    if (op_done_n != 1 || done_n != 1 || op_done_cyc != 12 || done_cyc != 12) begin
      tests_failed++;
      $display("FAIL zero_done: got op_done n=%0d cyc=%0d done n=%0d cyc=%0d expected 1 12 1 12",
               op_done_n, op_done_cyc, done_n, done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    run_tile(4, 4, 2, 0, 1'b0, 2);
    #1;
    tests_run++;
    if (aborted !== 1'b1 || wt_addr.size() != 3) begin
      tests_failed++; $display("FAIL mid_reached_beat2: got aborted=%0b beats=%0d expected 1 3", aborted, wt_addr.size());
    end
    tests_run++;
    if (any_out() !== 1'b0) begin
      tests_failed++; $display("FAIL mid_outputs_zero: got any=%0b expected 0", any_out());
    end
    done_seen = 0;
    repeat (3) begin @(negedge clk); #1; if (done) done_seen++; end
    rst = 1'b1;
    repeat (2) begin @(negedge clk); #1; if (done || busy) done_seen++; end
    tests_run++;
    if (done_seen != 0) begin
      tests_failed++; $display("FAIL mid_no_done: got %0d done/busy cycles expected 0", done_seen);
    end
    run_tile(2, 2, 2, 0, 1'b0, -1);
    tests_run++;
    if (cfg_ld_cyc != 1 || if_addr.size() != 2 || wt_addr.size() != 2 || m_dat.size() != 2 || done_n != 1) begin
      tests_failed++;
      $display("FAIL mid_restart: got cfg_cyc=%0d if=%0d wt=%0d words=%0d done=%0d expected 1 2 2 2 1",
               cfg_ld_cyc, if_addr.size(), wt_addr.size(), m_dat.size(), done_n);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_readback();
    test_stall();
    test_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
